// File: rtl/spart_rx_ctrl.sv
// Bus-side receive controller for the SPART: baud tick generator, RX drain FSM,
// small RX FIFO and the 4-register I/O-mapped bus decode.
module spart_rx_ctrl #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] DIV_RESET  = 16'd325
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    input  logic [7:0] db_in,
    output logic [7:0] db_out,
    output logic       rx_avail,
    output logic       en_16x,
    input  logic       rx_rda,
    input  logic [7:0] rx_data,
    output logic       rd_rx,
    input  logic       tbr,
    output logic [7:0] tx_data,
    output logic       wr_tx
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        ACK,
        WAIT
    } drain_state_t;

    drain_state_t state, next_state;

    logic [15:0] divisor;
    logic [15:0] baud_cnt;
    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic ovf, ovf_set;
    logic bus_rd, bus_wr, div_wr, status_rd;
    logic fifo_full, fifo_empty, push, pop;

    assign bus_rd     = iocs & iorw;
    assign bus_wr     = iocs & ~iorw;
    assign div_wr     = bus_wr & ioaddr[1];
    assign status_rd  = bus_rd & (ioaddr == 2'd1);
    assign fifo_full  = (count == FULL_COUNT);
    assign fifo_empty = (count == '0);
    assign push       = rd_rx;
    assign pop        = bus_rd & (ioaddr == 2'd0) & ~fifo_empty;

    assign en_16x   = (baud_cnt == divisor);
    assign rx_avail = ~fifo_empty;
    assign tx_data  = db_in;
    assign wr_tx    = bus_wr & (ioaddr == 2'd0) & tbr;

    // A divisor write restarts the tick period from the new value.
    always_ff @(posedge clk) begin
        if (rst) begin
            divisor  <= DIV_RESET;
            baud_cnt <= 16'd0;
        end else begin
            if (bus_wr && ioaddr == 2'd2) divisor[7:0]  <= db_in;
            if (bus_wr && ioaddr == 2'd3) divisor[15:8] <= db_in;
            if (div_wr || en_16x) baud_cnt <= 16'd0;
            else                  baud_cnt <= baud_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        rd_rx      = 1'b0;
        ovf_set    = 1'b0;
        case (state)
            IDLE: begin
                if (rx_rda) begin
                    if (!fifo_full) next_state = ACK;
                    else            ovf_set    = 1'b1;
                end
            end
            ACK: begin
                rd_rx      = 1'b1;
                next_state = WAIT;
            end
            WAIT: begin
                if (!rx_rda) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // A fresh overflow in the same cycle as a STATUS read keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst)            ovf <= 1'b0;
        else if (ovf_set)   ovf <= 1'b1;
        else if (status_rd) ovf <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= rx_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        db_out = 8'h00;
        if (bus_rd) begin
            case (ioaddr)
                2'd0: db_out = fifo_empty ? 8'h00 : mem[rd_ptr];
                2'd1: db_out = {4'b0000, ovf, fifo_full, tbr, rx_avail};
                2'd2: db_out = divisor[7:0];
                2'd3: db_out = divisor[15:8];
                default: db_out = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_spart_rx_ctrl.sv
// Scoreboard bench for spart_rx_ctrl: a queue-based receive/bus model predicts every
// bus read, and a monitor compares each read and every rd_rx pulse as it appears.
module tb_spart_rx_ctrl;

    localparam int          DEPTH   = 4;
    localparam logic [15:0] DIV_RST = 16'd325;

    logic       clk = 1'b0;
    logic       rst, iocs, iorw, rx_rda, tbr;
    logic [1:0] ioaddr;
    logic [7:0] db_in, rx_data;
    logic [7:0] db_out, tx_data;
    logic       rx_avail, en_16x, rd_rx, wr_tx;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_val_q [$];
    string      exp_name_q [$];

    logic [7:0]  m_fifo [$];
    bit          m_ovf;
    bit          m_pending;
    logic [7:0]  m_pend_byte;
    logic [15:0] m_div;
    int          m_acks = 0;
    int          dut_acks = 0;
    bit          rd_rx_prev = 1'b0;

    spart_rx_ctrl #(.FIFO_DEPTH(DEPTH), .DIV_RESET(DIV_RST)) dut (
        .clk(clk), .rst(rst), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
        .db_in(db_in), .db_out(db_out), .rx_avail(rx_avail), .en_16x(en_16x),
        .rx_rda(rx_rda), .rx_data(rx_data), .rd_rx(rd_rx), .tbr(tbr),
        .tx_data(tx_data), .wr_tx(wr_tx)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every bus read cycle consumes one scoreboard entry; rd_rx must be one cycle wide.
    always @(negedge clk) begin : monitor
        string      n;
        logic [7:0] e;
        if (iocs && iorw && !rst) begin
            if (exp_val_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_read: got %0h expected none", db_out);
            end else begin
                n = exp_name_q.pop_front();
                e = exp_val_q.pop_front();
                checkOutput(n, db_out, e);
            end
        end
        if (rd_rx_prev) checkOutput("rd_rx_width", rd_rx, 0);
        if (rd_rx && !rd_rx_prev) dut_acks++;
        rd_rx_prev = rd_rx;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expectRead(input string name, input logic [7:0] v);
        exp_name_q.push_back(name);
        exp_val_q.push_back(v);
    endtask

    // One bus access, held for exactly one clock; starts and ends 1 ns after a rising edge.
    task automatic applyStimulus(input logic rw, input logic [1:0] addr, input logic [7:0] data);
        iocs   = 1'b1;
        iorw   = rw;
        ioaddr = addr;
        db_in  = data;
        @(posedge clk);
        #1;
        iocs   = 1'b0;
        iorw   = 1'b0;
        db_in  = 8'($urandom);
    endtask

    task automatic waitAck(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rd_rx) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("[TB] FAIL ack_timeout: got no rd_rx expected rd_rx within 20 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drainPending();
        bit ok;
        if (m_pending) begin
            waitAck(ok);
            rx_rda = 1'b0;
            if (ok) begin
                m_acks++;
                m_fifo.push_back(m_pend_byte);
            end
            m_pending = 1'b0;
            tick(1);
        end
    endtask

    task automatic offerByte(input logic [7:0] b);
        bit ok;
        rx_rda  = 1'b1;
        rx_data = b;
        if (m_fifo.size() < DEPTH) begin
            waitAck(ok);
            rx_rda = 1'b0;
            if (ok) begin
                m_acks++;
                m_fifo.push_back(b);
            end
            tick(1);
        end else begin
            m_pending   = 1'b1;
            m_pend_byte = b;
            m_ovf       = 1'b1;
            tick(2);
        end
    endtask

    task automatic readData();
        logic [7:0] e;
        e = (m_fifo.size() == 0) ? 8'h00 : m_fifo.pop_front();
        expectRead("data_read", e);
        applyStimulus(1'b1, 2'd0, 8'($urandom));
        drainPending();
    endtask

    task automatic readStatus();
        logic [7:0] e;
        bit full_now;
        full_now = (m_fifo.size() == DEPTH);
        e = {4'b0000, m_ovf, full_now, tbr, m_fifo.size() != 0};
        expectRead("status_read", e);
        applyStimulus(1'b1, 2'd1, 8'($urandom));
        m_ovf = m_pending && full_now;
    endtask

    task automatic readDiv(input bit hi);
        expectRead(hi ? "div_hi_read" : "div_lo_read", hi ? m_div[15:8] : m_div[7:0]);
        applyStimulus(1'b1, hi ? 2'd3 : 2'd2, 8'($urandom));
    endtask

    // Cycle k after the write edge must tick exactly when k is a multiple of divisor+1.
    task automatic writeDiv(input bit hi, input logic [7:0] v, input int nchk);
        if (hi) m_div[15:8] = v;
        else    m_div[7:0]  = v;
        applyStimulus(1'b0, hi ? 2'd3 : 2'd2, v);
        for (int k = 1; k <= nchk; k++) begin
            @(negedge clk);
            checkOutput("en_16x_period", en_16x, (k % (int'(m_div) + 1)) == 0);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic writeData(input logic [7:0] v);
        iocs   = 1'b1;
        iorw   = 1'b0;
        ioaddr = 2'd0;
        db_in  = v;
        @(negedge clk);
        checkOutput("wr_tx", wr_tx, tbr);
        checkOutput("tx_data", tx_data, v);
        checkOutput("db_out_on_write", db_out, 8'h00);
        @(posedge clk);
        #1;
        iocs = 1'b0;
    endtask

    task automatic drainAll();
        while (m_fifo.size() != 0) readData();
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit ok;
        int op;
        rst = 1'b1; iocs = 1'b0; iorw = 1'b0; ioaddr = 2'd0; db_in = 8'h00;
        rx_rda = 1'b0; rx_data = 8'h00; tbr = 1'b1;
        m_ovf = 1'b0; m_pending = 1'b0; m_pend_byte = 8'h00; m_div = DIV_RST;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] reset state");
        checkOutput("reset_rx_avail", rx_avail, 0);
        checkOutput("reset_rd_rx", rd_rx, 0);
        checkOutput("reset_en_16x", en_16x, 0);
        checkOutput("reset_db_out", db_out, 8'h00);
        readStatus();
        readDiv(1'b0);
        readDiv(1'b1);

        $display("[TB] baud divisor");
        writeDiv(1'b0, 8'h03, 0);
        writeDiv(1'b1, 8'h00, 12);
        writeDiv(1'b0, 8'h00, 5);
        writeDiv(1'b0, 8'h05, 14);
        readDiv(1'b0);

        $display("[TB] single byte");
        tbr = 1'b1;
        offerByte(8'hA5);
        readStatus();
        readData();
        checkOutput("avail_after_pop", rx_avail, 0);

        $display("[TB] overflow");
        offerByte(8'h11); offerByte(8'h22); offerByte(8'h33); offerByte(8'h44);
        offerByte(8'h55);
        readStatus();
        checkOutput("ack_count_blocked", dut_acks, m_acks);
        repeat (5) readData();
        readStatus();

        $display("[TB] push and pop together");
        offerByte(8'h21); offerByte(8'h22);
        rx_rda  = 1'b1;
        rx_data = 8'h23;
        tick(1);
        expectRead("simul_pop", m_fifo.pop_front());
        iocs = 1'b1; iorw = 1'b1; ioaddr = 2'd0;
        @(negedge clk);
        checkOutput("simul_ack", rd_rx, 1);
        @(posedge clk);
        #1;
        iocs = 1'b0; iorw = 1'b0; rx_rda = 1'b0;
        m_acks++;
        m_fifo.push_back(8'h23);
        tick(1);
        readStatus();
        offerByte(8'h24); offerByte(8'h25);
        readStatus();
        drainAll();

        $display("[TB] empty read");
        readData();
        offerByte(8'h3C); offerByte(8'h3D);
        readData(); readData();
        readData();

        $display("[TB] random traffic");
        for (int i = 0; i < 80; i++) begin
            tbr = 1'($urandom);
            op  = $urandom_range(0, 6);
            case (op)
                0, 1: if (!m_pending) offerByte(8'($urandom)); else readData();
                2:    readData();
                3:    readStatus();
                4:    writeData(8'($urandom));
                5:    applyStimulus(1'b0, 2'd1, 8'($urandom));
                default: readDiv(1'($urandom));
            endcase
            checkOutput("rx_avail", rx_avail, m_fifo.size() != 0);
        end
        drainAll();
        checkOutput("ack_count", dut_acks, m_acks);

        $display("[TB] reset during ack");
        tbr = 1'b1;
        writeDiv(1'b0, 8'h07, 0);
        writeDiv(1'b1, 8'h00, 0);
        offerByte(8'h01);
        rx_rda  = 1'b1;
        rx_data = 8'h5C;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rd_rx) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput("ack_before_reset", ok, 1);
        if (ok) m_acks++;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_fifo.delete();
        m_ovf       = 1'b0;
        m_div       = DIV_RST;
        m_pending   = 1'b1;
        m_pend_byte = 8'h5C;
        readStatus();
        drainPending();
        readData();
        readDiv(1'b0);
        readDiv(1'b1);
        checkOutput("avail_end", rx_avail, 0);
        checkOutput("ack_count_final", dut_acks, m_acks);
        tick(2);
        checkOutput("scoreboard_empty", exp_val_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
